// File: rtl/alu_pkg.sv
// alu_pkg: opcode set, FSM state encoding and multiply-op helper shared by the ALU files
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_SLL   = 4'h5,
    OP_SRL   = 4'h6,
    OP_SRA   = 4'h7,
    OP_SLT   = 4'h8,
    OP_SLTU  = 4'h9,
    OP_ROL   = 4'hA,
    OP_ROR   = 4'hB,
    OP_MULLO = 4'hC,
    OP_MULHU = 4'hD
  } op_e;
  typedef enum logic {IDLE, MUL} state_e;
  function automatic logic is_mul(input logic [3:0] op);
    return op == OP_MULLO || op == OP_MULHU;
  endfunction
endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request (in_valid/in_ready, a, b, op) and result (out_valid/out_ready, y, flags) bundle; master drives requests, slave is the ALU
interface alu_mc_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, out_valid, out_ready;
  logic carry, overflow, zero, negative, err;
  logic [WIDTH-1:0] a, b, y;
  logic [3:0] op;
  modport master(
    output in_valid, a, b, op, out_ready,
    input in_ready, out_valid, y, carry, overflow, zero, negative, err
  );
  modport slave(
    input in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, carry, overflow, zero, negative, err
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: radix-2 shift-add unsigned multiplier, WIDTH steps; ports clk, rst, start, a, b in; done (high during last step), p (2*WIDTH product, final on done) out
module alu_mul_seq #(parameter int WIDTH = 32) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);
  localparam int CW = $clog2(WIDTH);
  logic busy;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0] sum;
  // acc = {partial, multiplier}; each step adds mcand on the low bit and shifts right
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    p = {sum, acc[WIDTH-1:1]};
  end
  assign done = busy && cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      mcand <= '0;
      acc <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      mcand <= a;
      acc <= {{WIDTH{1'b0}}, b};
    end else if (busy) begin
      acc <= p;
      cnt <= done ? '0 : cnt + 1'b1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake; ports clk, rst (async high), bus (alu_mc_if.slave: a, b, op request; y, carry, overflow, zero, negative, err result)
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SH = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst,
  alu_mc_if.slave bus
);
  state_e state;
  logic mul_hi, mul_done, accept, wr, sub, c, v, e;
  logic [2*WIDTH-1:0] prod;
  logic [SH-1:0] sh;
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] bb, res, nxt_y;
  assign bus.in_ready = state == IDLE && (!bus.out_valid || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign wr = state == MUL ? mul_done : accept && !is_mul(bus.op);
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(accept && is_mul(bus.op)),
    .a(bus.a),
    .b(bus.b),
    .done(mul_done),
    .p(prod)
  );
  always_comb begin
    sh = bus.b[SH-1:0];
    sub = bus.op == OP_SUB;
    bb = sub ? ~bus.b : bus.b;
    sum = {1'b0, bus.a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
    res = '0;
    c = 1'b0;
    v = 1'b0;
    e = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB: begin
        res = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = bus.a[WIDTH-1] == bb[WIDTH-1] && sum[WIDTH-1] != bus.a[WIDTH-1];
      end
      OP_AND:  res = bus.a & bus.b;
      OP_OR:   res = bus.a | bus.b;
      OP_XOR:  res = bus.a ^ bus.b;
      OP_SLL:  res = bus.a << sh;
      OP_SRL:  res = bus.a >> sh;
      OP_SRA:  res = $unsigned($signed(bus.a) >>> sh);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      // a shift by WIDTH yields 0, so amount 0 returns a unchanged
      OP_ROL:  res = (bus.a << sh) | (bus.a >> (WIDTH - int'(sh)));
      OP_ROR:  res = (bus.a >> sh) | (bus.a << (WIDTH - int'(sh)));
      OP_MULLO, OP_MULHU: res = '0;
      default: e = 1'b1;
    endcase
    nxt_y = state == MUL ? (mul_hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0]) : res;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mul_hi <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.y <= '0;
      bus.carry <= 1'b0;
      bus.overflow <= 1'b0;
      bus.err <= 1'b0;
      bus.negative <= 1'b0;
      bus.zero <= 1'b1;
    end else begin
      if (state == IDLE && accept && is_mul(bus.op)) begin
        state <= MUL;
        mul_hi <= bus.op == OP_MULHU;
      end else if (state == MUL && mul_done) begin
        state <= IDLE;
      end
      if (wr) begin
        bus.out_valid <= 1'b1;
        bus.y <= nxt_y;
        bus.carry <= state == IDLE && c;
        bus.overflow <= state == IDLE && v;
        bus.err <= state == IDLE && e;
        bus.zero <= nxt_y == '0;
        bus.negative <= nxt_y[WIDTH-1];
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc at WIDTH=8
module tb_alu_mc;
  import alu_pkg::*;
  typedef struct {
    string tag;
    logic [7:0] y;
    logic [4:0] f;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  exp_t exp_q[$];
  alu_mc_if #(.WIDTH(8)) bus();
  alu_mc #(.WIDTH(8)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] flags();
    return {bus.carry, bus.overflow, bus.zero, bus.negative, bus.err};
  endfunction
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t r;
    logic [8:0] s;
    logic [15:0] m;
    logic [7:0] y;
    logic c, v, e;
    logic [2:0] n;
    n = b[2:0];
    m = 16'(a) * 16'(b);
    c = 1'b0;
    v = 1'b0;
    e = 1'b0;
    y = 8'h00;
    case (op)
      4'h0: begin s = 9'(a) + 9'(b); y = s[7:0]; c = s[8]; v = a[7] == b[7] && y[7] != a[7]; end
      4'h1: begin y = a - b; c = a >= b; v = a[7] != b[7] && y[7] != a[7]; end
      4'h2: y = a & b;
      4'h3: y = a | b;
      4'h4: y = a ^ b;
      4'h5: y = a << n;
      4'h6: y = a >> n;
      4'h7: y = $unsigned($signed(a) >>> n);
      4'h8: y = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      4'h9: y = (a < b) ? 8'd1 : 8'd0;
      4'hA: begin y = a; for (int i = 0; i < int'(n); i++) y = {y[6:0], y[7]}; end
      4'hB: begin y = a; for (int i = 0; i < int'(n); i++) y = {y[0], y[7:1]}; end
      4'hC: y = m[7:0];
      4'hD: y = m[15:8];
      default: e = 1'b1;
    endcase
    r.tag = $sformatf("op%0h_%02h_%02h", op, a, b);
    r.y = y;
    r.f = {c, v, y == 8'h00, y[7], e};
    return r;
  endfunction
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(bus.out_valid), 64'(0));
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check({x.tag, "_y"}, 64'(bus.y), 64'(x.y));
        check({x.tag, "_flags"}, 64'(flags()), 64'(x.f));
      end
    end
  end
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int cnt;
    logic rdy_bad;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    #1;
    for (int i = 0; i < 40 && !bus.in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 64'(bus.in_ready), 64'(1));
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = ~a;
    bus.b = ~b;
    if (is_mul(op)) begin
      cnt = 0;
      rdy_bad = 1'b0;
      while (!bus.out_valid && cnt < 20) begin
        if (bus.in_ready) rdy_bad = 1'b1;
        @(posedge clk);
        #1;
        cnt++;
      end
      check("mul_latency", 64'(cnt), 64'(8));
      check("mul_in_ready_low", 64'(rdy_bad), 64'(0));
    end else begin
      check("latency1", 64'(bus.out_valid), 64'(1));
    end
  endtask
  initial begin
    logic seen;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = 8'h00;
    bus.b = 8'h00;
    bus.op = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 64'({bus.out_valid, bus.in_ready, bus.y, flags()}), 64'({1'b0, 1'b1, 8'h00, 5'b00100}));
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(OP_ADD, 8'h7F, 8'h01);
    check("add_ovf", 64'({bus.y, flags()}), 64'({8'h80, 5'b01010}));
    send(OP_SUB, 8'h00, 8'h01);
    check("sub_borrow", 64'({bus.y, flags()}), 64'({8'hFF, 5'b00010}));
    send(OP_SUB, 8'h05, 8'h05);
    check("sub_equal", 64'({bus.y, flags()}), 64'({8'h00, 5'b10100}));
    send(OP_MULLO, 8'h10, 8'h11);
    check("mullo", 64'(bus.y), 64'(8'h10));
    send(OP_MULHU, 8'h10, 8'h11);
    check("mulhu", 64'(bus.y), 64'(8'h01));
    send(OP_SRA, 8'h80, 8'h03);
    check("sra", 64'(bus.y), 64'(8'hF0));
    send(OP_ROR, 8'h01, 8'h01);
    check("ror", 64'(bus.y), 64'(8'h80));
    send(OP_SLT, 8'hFF, 8'h01);
    check("slt", 64'(bus.y), 64'(8'h01));
    send(OP_SLTU, 8'hFF, 8'h01);
    check("sltu", 64'(bus.y), 64'(8'h00));
    send(OP_ROL, 8'h81, 8'h08);
    check("rol_amt0", 64'(bus.y), 64'(8'h81));
    send(OP_MULHU, 8'hFF, 8'hFF);
    for (int k = 0; k < 40; k++) send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(OP_ADD, 8'h12, 8'h34);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("hold", 64'({bus.out_valid, bus.in_ready, bus.y, flags()}), 64'({1'b1, 1'b0, 8'h46, 5'b00000}));
    end
    bus.out_ready = 1'b1;
    send(OP_XOR, 8'h0F, 8'hF0);
    check("back_to_back", 64'({bus.y, flags()}), 64'({8'hFF, 5'b00010}));
    @(posedge clk);
    #1;
    bus.op = OP_MULLO;
    bus.a = 8'h33;
    bus.b = 8'h44;
    bus.in_valid = 1'b1;
    #1;
    for (int i = 0; i < 40 && !bus.in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    check("abort_accept_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_rst", 64'({bus.out_valid, bus.y, flags()}), 64'({1'b0, 8'h00, 5'b00100}));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(bus.in_ready), 64'(1));
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    check("abort_no_result", 64'(seen), 64'(0));
    send(4'hE, 8'h05, 8'h06);
    check("illegal_op", 64'({bus.y, flags()}), 64'({8'h00, 5'b00101}));
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
